ctrl_pipe_unit: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/ctrl_pipe_unit_if.sv | 59 +++++
 rtl/ctrl_pipe_unit_hazard_detect.sv | 68 ++++++
 rtl/ctrl_pipe_unit.sv | 149 ++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and stage-register bundles for the 16-bit MIPS control pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    // reg_DST: which instruction field names the destination register
    localparam logic [1:0] RDST_RT   = 2'b00;
    localparam logic [1:0] RDST_RD   = 2'b01;
    localparam logic [1:0] RDST_LINK = 2'b10;
    localparam logic [1:0] RDST_NONE = 2'b11;

    // mem_to_reg: write-back data source
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    // ALU_op: ALU control class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC  = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // jal writes the return address here
    localparam logic [2:0] LINK_REG = 3'd7;

    // Full decoded control bundle, as carried in the EX register
    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
    } ctrl_t;

    // Subset still needed once the instruction has left EX
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ID-stage control bundle in, per-stage controls and hazard signals out.
// Latency: n/a (wires only).
// Backpressure: stall/if_id_flush are returned to the fetch side on this bus.
// Ports: master = decoder/datapath side, slave = ctrl_pipe_unit.
// fwd_a/fwd_b exist only when CTRL_PIPE_FWD_EN is defined.
interface ctrl_pipe_unit_if #(parameter int REG_W = 3);
    logic             id_valid;
    logic [1:0]       id_reg_DST;
    logic             id_jump;
    logic             id_branch;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_ALU_src;
    logic             id_reg_write;
    logic [1:0]       id_mem_to_reg;
    logic [1:0]       id_ALU_op;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             redirect;

    logic             stall;
    logic             if_id_flush;
    logic [1:0]       ex_ALU_op;
    logic             ex_ALU_src;
    logic             ex_branch;
    logic             ex_jump;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       wb_mem_to_reg;
    logic             wb_reg_write;
    logic [REG_W-1:0] wb_dst;
`ifdef CTRL_PIPE_FWD_EN
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
`endif

    modport master (
        output id_valid, id_reg_DST, id_jump, id_branch, id_mem_read, id_mem_write,
               id_ALU_src, id_reg_write, id_mem_to_reg, id_ALU_op, id_rs, id_rt, id_rd,
               redirect,
        input  stall, if_id_flush, ex_ALU_op, ex_ALU_src, ex_branch, ex_jump,
               mem_read, mem_write, wb_mem_to_reg, wb_reg_write, wb_dst
`ifdef CTRL_PIPE_FWD_EN
             , fwd_a, fwd_b
`endif
    );

    modport slave (
        input  id_valid, id_reg_DST, id_jump, id_branch, id_mem_read, id_mem_write,
               id_ALU_src, id_reg_write, id_mem_to_reg, id_ALU_op, id_rs, id_rt, id_rd,
               redirect,
        output stall, if_id_flush, ex_ALU_op, ex_ALU_src, ex_branch, ex_jump,
               mem_read, mem_write, wb_mem_to_reg, wb_reg_write, wb_dst
`ifdef CTRL_PIPE_FWD_EN
             , fwd_a, fwd_b
`endif
    );
endinterface

// File: rtl/ctrl_pipe_unit_hazard_detect.sv
// Register-hazard stall and EX forwarding-select logic.
// Latency: purely combinational.
// Backpressure: o_stall holds PC/IF-ID; suppressed while a redirect squashes ID.
// Ports: ID source usage/fields, EX/MEM (and WB) effective-write info, redirect in;
// o_stall out, plus o_fwd_a/o_fwd_b when CTRL_PIPE_FWD_EN is defined.
module hazard_detect import cpu_ctrl_pkg::*; #(
    parameter int REG_W = 3
) (
    input  logic             i_rs_used,
    input  logic             i_rt_used,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_redirect,
    input  logic             i_ex_wr,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_dst,
    input  logic             i_mem_wr,
    input  logic [REG_W-1:0] i_mem_dst,
`ifdef CTRL_PIPE_FWD_EN
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_wb_wr,
    input  logic [REG_W-1:0] i_wb_dst,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
`endif
    output logic             o_stall
);

    logic w_ex_hit;
    logic w_load_use;
    logic w_hazard;

    // i_*_wr already folds in valid and dst != 0, so r0 can never match
    assign w_ex_hit = i_ex_wr &
                      ((i_rs_used & (i_id_rs != '0) & (i_id_rs == i_ex_dst)) |
                       (i_rt_used & (i_id_rt != '0) & (i_id_rt == i_ex_dst)));
    assign w_load_use = i_ex_mem_read & w_ex_hit;

`ifdef CTRL_PIPE_FWD_EN
    // ALU results forward from MEM/WB; only a load in EX has no value yet
    assign w_hazard = w_load_use;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if ((src != '0) && i_mem_wr && (src == i_mem_dst))
            return FWD_MEM;
        else if ((src != '0) && i_wb_wr && (src == i_wb_dst))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign o_fwd_a = fwd_sel(i_ex_rs);
    assign o_fwd_b = fwd_sel(i_ex_rt);
`else
    logic w_mem_hit;

    assign w_mem_hit = i_mem_wr &
                       ((i_rs_used & (i_id_rs != '0) & (i_id_rs == i_mem_dst)) |
                        (i_rt_used & (i_id_rt != '0) & (i_id_rt == i_mem_dst)));
    // WB writes before the ID read in the same cycle, so only EX/MEM matter
    assign w_hazard = w_load_use | w_ex_hit | w_mem_hit;
`endif

    // The ID instruction is being squashed anyway, so never hold it
    assign o_stall = w_hazard & ~i_redirect;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Carries decoded controls through EX/MEM/WB registers with stall and flush handling.
// Latency: ID controls reach ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles after sampling.
// Backpressure: stall/if_id_flush are combinational; a stall or redirect loads an EX bubble.
// Ports: clk, rst_n (async active-low), bus (ctrl_pipe_unit_if.slave).
// Optional forwarding selects: define CTRL_PIPE_FWD_EN.
module ctrl_pipe_unit import cpu_ctrl_pkg::*; #(
    parameter int REG_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    ctrl_pipe_unit_if.slave bus
);

    ctrl_t            w_id_ctrl;
    logic [REG_W-1:0] w_id_dst;
    logic             w_rs_used;
    logic             w_rt_used;
    logic             w_stall;
    logic             w_ex_load;
    logic             w_ex_wr;
    logic             w_mem_wr;

    ctrl_t            r_ex_ctrl;
    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_dst;
    mem_ctrl_t        r_mem_ctrl;
    logic             r_mem_valid;
    logic [REG_W-1:0] r_mem_dst;
    wb_ctrl_t         r_wb_ctrl;
    logic [REG_W-1:0] r_wb_dst;

    assign w_id_ctrl = '{jump:       bus.id_jump,
                         branch:     bus.id_branch,
                         mem_read:   bus.id_mem_read,
                         mem_write:  bus.id_mem_write,
                         alu_src:    bus.id_ALU_src,
                         reg_write:  bus.id_reg_write,
                         mem_to_reg: bus.id_mem_to_reg,
                         alu_op:     bus.id_ALU_op};

    always_comb begin
        w_id_dst = '0;
        case (bus.id_reg_DST)
            RDST_RT:   w_id_dst = bus.id_rt;
            RDST_RD:   w_id_dst = bus.id_rd;
            RDST_LINK: w_id_dst = REG_W'(LINK_REG);
            default:   w_id_dst = '0;
        endcase
    end

    // rt is a source for R-format, beq (ALU_src=0) and sw; jumps read nothing
    assign w_rs_used = bus.id_valid & ~bus.id_jump;
    assign w_rt_used = bus.id_valid & ~bus.id_jump & (~bus.id_ALU_src | bus.id_mem_write);

    assign w_ex_wr  = r_ex_valid  & r_ex_ctrl.reg_write  & (r_ex_dst  != '0);
    assign w_mem_wr = r_mem_valid & r_mem_ctrl.reg_write & (r_mem_dst != '0);

    assign w_ex_load = bus.id_valid & ~w_stall & ~bus.redirect;

`ifdef CTRL_PIPE_FWD_EN
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
    logic             r_wb_valid;
    logic             w_wb_wr;

    assign w_wb_wr = r_wb_valid & r_wb_ctrl.reg_write & (r_wb_dst != '0);

    // Unused sources are stored as r0 so they never select a forward path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            r_ex_rs    <= (w_ex_load & w_rs_used) ? bus.id_rs : '0;
            r_ex_rt    <= (w_ex_load & w_rt_used) ? bus.id_rt : '0;
            r_wb_valid <= r_mem_valid;
        end
    end
`endif

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .i_rs_used     (w_rs_used),
        .i_rt_used     (w_rt_used),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_redirect    (bus.redirect),
        .i_ex_wr       (w_ex_wr),
        .i_ex_mem_read (r_ex_ctrl.mem_read),
        .i_ex_dst      (r_ex_dst),
        .i_mem_wr      (w_mem_wr),
        .i_mem_dst     (r_mem_dst),
`ifdef CTRL_PIPE_FWD_EN
        .i_ex_rs       (r_ex_rs),
        .i_ex_rt       (r_ex_rt),
        .i_wb_wr       (w_wb_wr),
        .i_wb_dst      (r_wb_dst),
        .o_fwd_a       (bus.fwd_a),
        .o_fwd_b       (bus.fwd_b),
`endif
        .o_stall       (w_stall)
    );

    // Bubbles are all-zero so downstream consumers need no valid gating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctrl   <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_dst    <= '0;
            r_mem_ctrl  <= '0;
            r_mem_valid <= 1'b0;
            r_mem_dst   <= '0;
            r_wb_ctrl   <= '0;
            r_wb_dst    <= '0;
        end else begin
            if (w_ex_load) begin
                r_ex_ctrl  <= w_id_ctrl;
                r_ex_valid <= 1'b1;
                r_ex_dst   <= w_id_dst;
            end else begin
                r_ex_ctrl  <= '0;
                r_ex_valid <= 1'b0;
                r_ex_dst   <= '0;
            end
            r_mem_ctrl  <= '{mem_read:   r_ex_ctrl.mem_read,
                             mem_write:  r_ex_ctrl.mem_write,
                             reg_write:  r_ex_ctrl.reg_write,
                             mem_to_reg: r_ex_ctrl.mem_to_reg};
            r_mem_valid <= r_ex_valid;
            r_mem_dst   <= r_ex_dst;
            r_wb_ctrl   <= '{reg_write:  r_mem_ctrl.reg_write,
                             mem_to_reg: r_mem_ctrl.mem_to_reg};
            r_wb_dst    <= r_mem_dst;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.if_id_flush   = bus.redirect;
    assign bus.ex_ALU_op     = r_ex_ctrl.alu_op;
    assign bus.ex_ALU_src    = r_ex_ctrl.alu_src;
    assign bus.ex_branch     = r_ex_ctrl.branch;
    assign bus.ex_jump       = r_ex_ctrl.jump;
    assign bus.mem_read      = r_mem_ctrl.mem_read;
    assign bus.mem_write     = r_mem_ctrl.mem_write;
    assign bus.wb_mem_to_reg = r_wb_ctrl.mem_to_reg;
    assign bus.wb_reg_write  = r_wb_ctrl.reg_write;
    assign bus.wb_dst        = r_wb_dst;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: hazards, flush, link write-back, async reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_ctrl_pipe_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit_if #(.REG_W(3)) bus ();

    ctrl_pipe_unit #(.REG_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // {stall, flush, ex_ALU_op, ex_ALU_src, ex_branch, ex_jump, mem_read, mem_write,
    //  wb_mem_to_reg, wb_reg_write, wb_dst}
    function automatic logic [31:0] all_outs();
        return 32'({bus.stall, bus.if_id_flush, bus.ex_ALU_op, bus.ex_ALU_src, bus.ex_branch,
                    bus.ex_jump, bus.mem_read, bus.mem_write, bus.wb_mem_to_reg,
                    bus.wb_reg_write, bus.wb_dst});
    endfunction

    function automatic logic [31:0] ex_vec();
        return 32'({bus.ex_ALU_op, bus.ex_ALU_src, bus.ex_branch, bus.ex_jump});
    endfunction

    task automatic set_id(input logic v, input logic [1:0] rdst, input logic j, input logic br,
                          input logic mr, input logic mw, input logic asrc, input logic rw,
                          input logic [1:0] m2r, input logic [1:0] aop,
                          input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        bus.id_valid      = v;
        bus.id_reg_DST    = rdst;
        bus.id_jump       = j;
        bus.id_branch     = br;
        bus.id_mem_read   = mr;
        bus.id_mem_write  = mw;
        bus.id_ALU_src    = asrc;
        bus.id_reg_write  = rw;
        bus.id_mem_to_reg = m2r;
        bus.id_ALU_op     = aop;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
    endtask

    task automatic id_nop();
        set_id(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 3'd2, 3'd2, 3'd2);
    endtask
    task automatic id_lw(input logic [2:0] rs, input logic [2:0] rt);
        set_id(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, rs, rt, 3'd0);
    endtask
    task automatic id_add(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        set_id(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, rs, rt, rd);
    endtask
    task automatic id_addi(input logic [2:0] rs, input logic [2:0] rt);
        set_id(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, rs, rt, 3'd0);
    endtask
    task automatic id_sw(input logic [2:0] rs, input logic [2:0] rt);
        set_id(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, rs, rt, 3'd0);
    endtask
    task automatic id_jal(input logic [2:0] rs, input logic [2:0] rt);
        set_id(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, rs, rt, 3'd0);
    endtask
    task automatic id_beq(input logic [2:0] rs, input logic [2:0] rt);
        set_id(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, rs, rt, 3'd0);
    endtask

    // Inputs change 2 time units after the rising edge; checks happen 1 unit later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic settle();
        #1;
    endtask
    task automatic drain();
        id_nop();
        repeat (3) tick();
    endtask

    initial begin
        bus.redirect = 1'b0;
        id_nop();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_val("reset_outs", all_outs(), 0);
`ifdef CTRL_PIPE_FWD_EN
        check_val("reset_fwd", 32'({bus.fwd_a, bus.fwd_b}), 0);
`endif
        rst_n = 1'b1;

        // lw r2 followed by add r4 = r2 + r5
        id_lw(3'd1, 3'd2);
        settle();
        check_val("lw_no_stall", 32'(bus.stall), 0);
        tick();
        id_add(3'd4, 3'd2, 3'd5);
        settle();
        check_val("lu_stall1", 32'(bus.stall), 1);
        check_val("lu_ex_lw", ex_vec(), 32'h4);
        check_val("lu_flush0", 32'(bus.if_id_flush), 0);
        tick();
        settle();
        check_val("lu_ex_bubble", ex_vec(), 0);
        check_val("lu_mem_read", 32'(bus.mem_read), 1);
`ifdef CTRL_PIPE_FWD_EN
        check_val("lu_stall2", 32'(bus.stall), 0);
        tick();
        id_nop();
        settle();
        check_val("lu_ex_add", 32'(bus.ex_ALU_op), 2);
        check_val("lu_fwd_a", 32'(bus.fwd_a), 2);
        check_val("lu_fwd_b", 32'(bus.fwd_b), 0);
        check_val("lu_wb_dst", 32'(bus.wb_dst), 2);
`else
        check_val("lu_stall2", 32'(bus.stall), 1);
        tick();
        settle();
        check_val("lu_stall3", 32'(bus.stall), 0);
        check_val("lu_wb_dst", 32'(bus.wb_dst), 2);
        check_val("lu_wb_m2r", 32'(bus.wb_mem_to_reg), 1);
        tick();
        id_nop();
        settle();
        check_val("lu_ex_add", 32'(bus.ex_ALU_op), 2);
`endif

        // addi r3 followed by add r6 = r3 + r3
        drain();
        id_addi(3'd0, 3'd3);
        settle();
        tick();
        id_add(3'd6, 3'd3, 3'd3);
        settle();
`ifdef CTRL_PIPE_FWD_EN
        check_val("alu_stall", 32'(bus.stall), 0);
        tick();
        id_nop();
        settle();
        check_val("alu_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'h5);
`else
        check_val("alu_stall_ex", 32'(bus.stall), 1);
        tick();
        settle();
        check_val("alu_stall_mem", 32'(bus.stall), 1);
        tick();
        settle();
        check_val("alu_wb_nostall", 32'(bus.stall), 0);
        check_val("alu_wb_dst", 32'(bus.wb_dst), 3);
        tick();
        id_nop();
        settle();
        check_val("alu_ex_add", 32'(bus.ex_ALU_op), 2);
`endif

        // add writing r0 then add reading r0
        drain();
        id_add(3'd0, 3'd1, 3'd1);
        settle();
        tick();
        id_add(3'd5, 3'd0, 3'd2);
        settle();
        check_val("r0_no_stall", 32'(bus.stall), 0);
        tick();
        id_nop();
        settle();
`ifdef CTRL_PIPE_FWD_EN
        check_val("r0_fwd_a", 32'(bus.fwd_a), 0);
`endif
        tick();
        settle();
        check_val("r0_wb_rw", 32'(bus.wb_reg_write), 1);
        check_val("r0_wb_dst", 32'(bus.wb_dst), 0);

        // sw uses rt, addi does not; an invalid ID never hazards
        drain();
        id_addi(3'd0, 3'd4);
        settle();
        tick();
        id_sw(3'd1, 3'd4);
        settle();
`ifdef CTRL_PIPE_FWD_EN
        check_val("sw_rt_stall", 32'(bus.stall), 0);
`else
        check_val("sw_rt_stall", 32'(bus.stall), 1);
`endif
        id_addi(3'd1, 3'd4);
        settle();
        check_val("addi_rt_unused", 32'(bus.stall), 0);
        set_id(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 3'd4, 3'd4, 3'd4);
        settle();
        check_val("invalid_no_haz", 32'(bus.stall), 0);
        tick();
        id_beq(3'd0, 3'd0);
        settle();
        check_val("invalid_ex_zero", ex_vec(), 0);
        tick();
        id_nop();
        settle();
        check_val("beq_ex", ex_vec(), 32'ha);

        // jal right behind lw r2: jump has no sources, link goes to r7
        drain();
        id_lw(3'd1, 3'd2);
        settle();
        tick();
        id_jal(3'd2, 3'd2);
        settle();
        check_val("jal_no_stall", 32'(bus.stall), 0);
        tick();
        id_nop();
        settle();
        check_val("jal_ex_jump", 32'(bus.ex_jump), 1);
        check_val("jal_lw_mem", 32'(bus.mem_read), 1);
        tick();
        tick();
        settle();
        check_val("jal_wb_dst", 32'(bus.wb_dst), 7);
        check_val("jal_wb_m2r", 32'(bus.wb_mem_to_reg), 2);
        check_val("jal_wb_rw", 32'(bus.wb_reg_write), 1);

        // load-use coincident with redirect
        drain();
        id_lw(3'd1, 3'd2);
        settle();
        tick();
        id_add(3'd4, 3'd2, 3'd5);
        bus.redirect = 1'b1;
        settle();
        check_val("rd_stall", 32'(bus.stall), 0);
        check_val("rd_flush", 32'(bus.if_id_flush), 1);
        tick();
        bus.redirect = 1'b0;
        id_nop();
        settle();
        check_val("rd_ex_bubble", ex_vec(), 0);
        check_val("rd_flush_off", 32'(bus.if_id_flush), 0);
        check_val("rd_lw_mem", 32'(bus.mem_read), 1);

        // reset pulsed during a stall
        drain();
        id_lw(3'd1, 3'd2);
        settle();
        tick();
        id_add(3'd4, 3'd2, 3'd5);
        settle();
        check_val("rst_pre_stall", 32'(bus.stall), 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_async", all_outs(), 0);
`ifdef CTRL_PIPE_FWD_EN
        check_val("rst_async_fwd", 32'({bus.fwd_a, bus.fwd_b}), 0);
`endif
        id_nop();
        tick();
        tick();
        settle();
        check_val("rst_hold", all_outs(), 0);
        rst_n = 1'b1;
        tick();
        settle();
        check_val("post_rst_idle", all_outs(), 0);
        id_add(3'd4, 3'd2, 3'd5);
        settle();
        check_val("post_rst_no_stall", 32'(bus.stall), 0);
        tick();
        id_nop();
        settle();
        check_val("post_rst_ex_add", 32'(bus.ex_ALU_op), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
